// File: rtl/mux_pipe.sv
// N:1 data selector followed by DEPTH register stages with stall/flush, valid and
// select-error tracking, and a saturating count of valid illegal selects.
module mux_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    output logic                    sel_err,
    output logic [CNT_W-1:0]        err_count
);

    if (NUM_IN < 2 || NUM_IN > 16 || DEPTH < 1 || DEPTH > 4 || SEL_W < $clog2(NUM_IN))
    begin : g_param_check
        $error("mux_pipe: illegal parameters (NUM_IN 2..16, 2**SEL_W >= NUM_IN, DEPTH 1..4)");
    end

    logic [WIDTH-1:0] mux_data;
    logic             mux_legal;

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Illegal selects yield zero data rather than holding the previous value.
    always_comb begin
        mux_data  = '0;
        mux_legal = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                mux_data  = din[k*WIDTH +: WIDTH];
                mux_legal = 1'b1;
            end
        end
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        err_d       = err_q;
        err_count_d = err_count_q;
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_d[i] = '0;
            end
            valid_d = '0;
            err_d   = '0;
        end else if (!stall) begin
            data_d[0]  = mux_data;
            valid_d[0] = in_valid;
            err_d[0]   = ~mux_legal;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
            end
            if (in_valid && !mux_legal && err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            err_q       <= '0;
            err_count_q <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign dout      = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign sel_err   = err_q[DEPTH-1];
    assign err_count = err_count_q;

endmodule
